buzzer_arbiter: RTL and testbench
=================================

# buzzer_arbiter

Shares the single board buzzer among up to `N_REQ` requesters, such as button handlers, alarm logic or UI feedback. Each requester asks for a beep with its own pitch and duration. A round-robin arbiter grants one request at a time, and a tone generator drives the buzzer pin with a square wave for the requested number of milliseconds. The block sits between the requesting logic and the `buzzer` output pin, and it replaces direct counter-bit drive of that pin.

## Interface
- `CLK_HZ`, 50_000_000: system clock frequency; documentation and sanity checks only.
- `N_REQ`, 4: number of requesters, 2..8.
- `TICK_DIV`, 50_000: clk cycles per duration tick (1 ms at 50 MHz).
- `GAP_TICKS`, 20: silent ticks between beeps; used only with `BUZZER_GAP_EN`.
- `clk`  in  1  system clock, 50 MHz.
- `rst`  in  1  reset; **one clock; reset is synchronous and active-high**.
- `req`  in  N_REQ  level request per requester.
- `half_period`  in  N_REQ*16  per requester; requester i uses bits [16i+15:16i]; tone half-period in clk cycles; 0 = rest (silent).
- `dur_ticks`  in  N_REQ*10  per requester; duration in ticks; 0 = empty beep.
- `stop`  in  1  synchronous abort of the current beep.
- `grant`  out  N_REQ  one-hot, one-cycle pulse; the winner's operands are latched.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when a beep completes normally.
- `buzzer`  out  1  speaker drive.

## Operation
- States: IDLE, PLAY, GAP. GAP exists only with `BUZZER_GAP_EN`.
- **IDLE:** if `req` is nonzero, select the first set bit at or after `rr_ptr`, wrapping modulo N_REQ.
  - Latch that requester's `half_period` and `dur_ticks`.
  - Pulse `grant[i]`.
  - Set `rr_ptr` = (i+1) mod N_REQ.
  - Clear the tone and tick counters, then enter PLAY.
- **Request handshake:**
  - A requester holds `req` until it sees `grant`, then drops `req` in the next cycle.
  - A `req` still high on return to IDLE counts as a new request.
  - A requester may drop `req` before it is granted; the request is then withdrawn with no side effects.
- **PLAY, tone:**
  - `buzzer` starts at 0.
  - The tone counter counts 0..hp-1. When it reaches hp-1, `buzzer` toggles and the counter wraps to 0.
  - If hp = 0, `buzzer` is held at 0.
- **PLAY, duration:**
  - The prescaler counts 0..TICK_DIV-1 and issues one tick per wrap.
  - The remaining-ticks counter is loaded with `dur_ticks` and decrements on each tick.
  - When it reaches 0, pulse `done`, force `buzzer` to 0, and enter GAP (or IDLE without `BUZZER_GAP_EN`).
- **`dur_ticks` = 0:** grant as normal, then `done` pulses in the next cycle; no tone cycles are produced.
- **GAP:** `buzzer` stays at 0 for GAP_TICKS ticks, then the block returns to IDLE. No grants are issued during GAP.
- **`stop`:**
  - In PLAY or GAP: next state is IDLE, `buzzer` goes to 0, and no `done` is pulsed.
  - In IDLE: `stop` has priority over `req`, so no grant is issued in that cycle.
- **Reset (any state, including mid-beep):**
  - State IDLE.
  - `buzzer`, `grant`, `done` and `busy` all 0.
  - `rr_ptr` = 0.
  - All counters cleared.
- **Widths:**
  - Tone counter 16 bits; prescaler sized by `$clog2(TICK_DIV)`; tick counters 10 bits.
  - No overflow is possible: each counter wraps or stops at its programmed bound.
  - Operand inputs are ignored except on the grant cycle.

## Timing
- `req` sampled high at edge k in IDLE → `grant` and `busy` high in cycle k+1; PLAY starts in cycle k+1.
- The PLAY phase lasts exactly dur_ticks*TICK_DIV cycles, counted from the grant cycle.
- `done` is high in the first cycle after PLAY. In that same cycle `buzzer` = 0 and the state is GAP or IDLE.
- First `buzzer` rising edge: hp cycles after the grant cycle. Tone period thereafter: 2*hp cycles.
- The earliest possible next grant is 1 cycle after IDLE is re-entered (0 gap ticks without the macro).
- All outputs are registered; there are no combinational paths from input to output.

## Configuration
- `BUZZER_GAP_EN` defined: the GAP state is compiled in, inserting GAP_TICKS silent ticks after every normally completed beep. Consecutive beeps are then audibly separated.
- `BUZZER_GAP_EN` undefined: PLAY goes directly to IDLE. Back-to-back beeps are separated only by the one IDLE cycle. `GAP_TICKS` is unused.

## Structure
- Package `buzzer_pkg`:
  - state enum `buzz_state_t` (IDLE, PLAY, GAP);
  - localparams `HP_W` = 16 and `DUR_W` = 10.
- Sub-module `tone_gen`:
  - ports: `clk`, `rst`, `en`, `half_period[15:0]`, `buzzer`;
  - contents: tone counter and output toggle; clears while `en` = 0.
- The top level holds the round-robin arbiter, the prescaler, the tick counters and the FSM.

## Test plan
Bench parameters: TICK_DIV = 10, GAP_TICKS = 2, N_REQ = 4.
- Single request: `req` = 0001, hp = 3, dur = 2. Expect `grant` = 0001 one cycle later and 20 PLAY cycles with `buzzer` 0,0,0,1,1,1,… Then `done` pulses once and `buzzer` = 0.
- Contention: `req` = 1111 held continuously, with each requester dropping `req` after its grant. Expect grants in the order 0001, 0010, 0100, 1000. Then raise `req` = 0101 with `rr_ptr` = 0 → grant 0001, then 0100.
- Rest and empty beep: hp = 0, dur = 3 → `buzzer` stays 0 for 30 cycles, then `done`. dur = 0 → `done` one cycle after `grant`.
- Abort: assert `stop` 7 cycles into PLAY → IDLE next cycle, `buzzer` = 0, `done` never pulses, `busy` falls.
- Reset mid-beep: assert `rst` during PLAY with `buzzer` = 1 → next cycle all outputs 0. Then `req` = 0110 → `grant` = 0010, because `rr_ptr` = 0.
- Gap: with `BUZZER_GAP_EN` defined, two back-to-back requests → 20 idle-buzzer cycles between the first `done` and the second `grant`. Without the macro → a 1-cycle separation.

Source files
------------

// File: rtl/buzzer_pkg.sv
// Shared state type and operand widths for the buzzer arbiter and its tone generator.
package buzzer_pkg;

  localparam int HP_W  = 16;
  localparam int DUR_W = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } buzz_state_t;

endpackage

// File: rtl/buzzer_arbiter_tone_gen.sv
// Square-wave generator: toggles the buzzer every half_period clk cycles while enabled.
module tone_gen
  import buzzer_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [HP_W-1:0] half_period,
  output logic            buzzer
);

  logic [HP_W-1:0] tone_cnt;

  // A zero half-period is a rest, so it holds the pin low just like a disabled generator.
  always_ff @(posedge clk) begin
    if (rst || !en || half_period == '0) begin
      tone_cnt <= '0;
      buzzer   <= 1'b0;
    end else if (tone_cnt == half_period - HP_W'(1)) begin
      tone_cnt <= '0;
      buzzer   <= ~buzzer;
    end else begin
      tone_cnt <= tone_cnt + HP_W'(1);
    end
  end

endmodule

// File: rtl/buzzer_arbiter.sv
// Round-robin sharing of one buzzer among N_REQ requesters; each grant plays one timed tone.
// Define BUZZER_GAP_EN to insert GAP_TICKS silent ticks after every normally completed beep.
module buzzer_arbiter
  import buzzer_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int N_REQ     = 4,
  parameter int TICK_DIV  = 50_000,
  parameter int GAP_TICKS = 20
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*HP_W-1:0]    half_period,
  input  logic [N_REQ*DUR_W-1:0]   dur_ticks,
  input  logic                     stop,
  output logic [N_REQ-1:0]         grant,
  output logic                     busy,
  output logic                     done,
  output logic                     buzzer
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  if (N_REQ < 2 || N_REQ > 8 || TICK_DIV < 1 || CLK_HZ < 1 ||
      GAP_TICKS < 0 || GAP_TICKS > 1023) begin : g_param_check
    $error("buzzer_arbiter: parameter out of range");
  end

  buzz_state_t      state, state_next;
  logic [PTR_W-1:0] rr_ptr;
  logic [HP_W-1:0]  hp_q;
  logic [DUR_W-1:0] remain;
  logic [PRE_W-1:0] presc;
  logic             tick;
  logic             play_end;
  logic             gap_end;
  logic             win_valid;
  logic [PTR_W-1:0] win_idx;
  int               cand;
  logic             take;
  logic [N_REQ-1:0] grant_next;
  logic             done_next;
  logic             busy_next;
  logic             tone_en;

  // Scan from the highest offset down so the first requester at or after rr_ptr wins.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int off = N_REQ - 1; off >= 0; off--) begin
      cand = int'(rr_ptr) + off;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (req[cand]) begin
        win_valid = 1'b1;
        win_idx   = PTR_W'(cand);
      end
    end
  end

  assign tick     = (presc == PRE_LAST);
  assign play_end = (state == PLAY) && (remain == '0 || (tick && remain == DUR_W'(1)));

`ifdef BUZZER_GAP_EN
  logic [DUR_W-1:0] gap_cnt;
  assign gap_end = (state == GAP) && (gap_cnt == '0 || (tick && gap_cnt == DUR_W'(1)));
`else
  assign gap_end = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      rr_ptr <= '0;
      grant  <= '0;
      done   <= 1'b0;
      busy   <= 1'b0;
    end else begin
      state <= state_next;
      grant <= grant_next;
      done  <= done_next;
      busy  <= busy_next;
      if (take) rr_ptr <= (win_idx == PTR_W'(N_REQ - 1)) ? '0 : win_idx + PTR_W'(1);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (!stop && win_valid) state_next = PLAY;
      PLAY: begin
        if (stop) state_next = IDLE;
`ifdef BUZZER_GAP_EN
        else if (play_end) state_next = GAP;
`else
        else if (play_end) state_next = IDLE;
`endif
      end
      GAP:     if (stop || gap_end) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // These are next-cycle values; the state register block makes every output a flop.
  always_comb begin
    grant_next = '0;
    take       = (state == IDLE) && (state_next == PLAY);
    if (take) grant_next[win_idx] = 1'b1;
    done_next  = (state == PLAY) && !stop && play_end;
    busy_next  = (state_next != IDLE);
    tone_en    = (state == PLAY) && (state_next == PLAY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hp_q    <= '0;
      remain  <= '0;
      presc   <= '0;
`ifdef BUZZER_GAP_EN
      gap_cnt <= '0;
`endif
    end else if (take) begin
      hp_q   <= half_period[int'(win_idx)*HP_W +: HP_W];
      remain <= dur_ticks[int'(win_idx)*DUR_W +: DUR_W];
      presc  <= '0;
    end else if (state == PLAY && state_next == PLAY) begin
      presc <= tick ? '0 : presc + PRE_W'(1);
      if (tick) remain <= remain - DUR_W'(1);
`ifdef BUZZER_GAP_EN
    end else if (state == PLAY && state_next == GAP) begin
      presc   <= '0;
      gap_cnt <= DUR_W'(GAP_TICKS);
    end else if (state == GAP && state_next == GAP) begin
      presc <= tick ? '0 : presc + PRE_W'(1);
      if (tick) gap_cnt <= gap_cnt - DUR_W'(1);
`endif
    end else begin
      presc <= '0;
    end
  end

  tone_gen u_tone_gen (
    .clk         (clk),
    .rst         (rst),
    .en          (tone_en),
    .half_period (hp_q),
    .buzzer      (buzzer)
  );

endmodule

// File: tb/tb_buzzer_arbiter.sv
// Self-checking bench for buzzer_arbiter (TICK_DIV=10, GAP_TICKS=2, N_REQ=4).
module tb_buzzer_arbiter;

  localparam int N  = 4;
  localparam int TD = 10;
  localparam int GT = 2;
`ifdef BUZZER_GAP_EN
  localparam int GAP_CYC   = GT * TD + 1;
  localparam bit DONE_BUSY = 1'b1;
`else
  localparam int GAP_CYC   = 1;
  localparam bit DONE_BUSY = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req;
  logic [N*16-1:0] half_period;
  logic [N*10-1:0] dur_ticks;
  logic          stop;
  logic [N-1:0]  grant;
  logic          busy;
  logic          done;
  logic          buzzer;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string      name;
    int         idx;
    int         hp;
    int         dur;
    logic [3:0] exp_grant;
    int         exp_play;
  } beep_vec_t;

  beep_vec_t vecs[5];

  buzzer_arbiter #(
    .CLK_HZ    (50_000_000),
    .N_REQ     (N),
    .TICK_DIV  (TD),
    .GAP_TICKS (GT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .half_period (half_period),
    .dur_ticks   (dur_ticks),
    .stop        (stop),
    .grant       (grant),
    .busy        (busy),
    .done        (done),
    .buzzer      (buzzer)
  );

  always #5 clk = ~clk;

  initial begin
    #500_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] r, input logic s);
    req  = r;
    stop = s;
  endtask

  task automatic set_ops(input int idx, input int hp, input int dur);
    half_period[idx*16 +: 16] = 16'(hp);
    dur_ticks[idx*10 +: 10]   = 10'(dur);
  endtask

  // Expected pin level c cycles after the grant cycle: high in every odd half-period.
  function automatic int model_buzz(input int hp, input int c);
    return (hp == 0) ? 0 : ((c / hp) % 2);
  endfunction

  function automatic int model_pick(input logic [N-1:0] pending, input int ptr);
    for (int off = 0; off < N; off++)
      if (pending[(ptr + off) % N]) return (ptr + off) % N;
    return 0;
  endfunction

  task automatic wait_grant(output logic [N-1:0] g);
    int n;
    g = '0;
    n = 0;
    while (g == '0 && n < 200) begin
      @(negedge clk);
      n++;
      if (grant != '0) g = grant;
    end
    if (g == '0) checkOutput("grant_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) checkOutput("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    applyStimulus('0, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Called on the grant cycle; checks the waveform through PLAY and the done cycle.
  task automatic follow_beep(input int hp, input int play);
    for (int c = 0; c < play; c++) begin
      if (c > 0) @(negedge clk);
      checkOutput("play_buzzer", 32'(buzzer), 32'(model_buzz(hp, c)));
      checkOutput("play_done_low", 32'(done), 32'd0);
      if (c == 0) checkOutput("play_busy", 32'(busy), 32'd1);
    end
    @(negedge clk);
    checkOutput("done_pulse", 32'(done), 32'd1);
    checkOutput("done_buzzer", 32'(buzzer), 32'd0);
    checkOutput("done_busy", 32'(busy), 32'(DONE_BUSY));
  endtask

  initial begin
    logic [N-1:0] g;
    logic [N-1:0] pending;
    logic [3:0]   exp_order [4];
    int           ptr, pred, n;
    int           hp_r [N];
    int           dur_r [N];
    bit           ok, seen, quiet, got;

    rst = 1'b1;
    req = '0;
    stop = 1'b0;
    half_period = '0;
    dur_ticks = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset_grant", 32'(grant), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_buzzer", 32'(buzzer), 32'd0);
    rst = 1'b0;

    vecs[0] = '{"single", 0, 3, 2, 4'b0001, 20};
    vecs[1] = '{"rest",   2, 0, 3, 4'b0100, 30};
    vecs[2] = '{"empty",  1, 5, 0, 4'b0010, 1};
    vecs[3] = '{"fast",   3, 1, 1, 4'b1000, 10};
    vecs[4] = '{"slow",   0, 7, 2, 4'b0001, 20};

    for (int v = 0; v < 5; v++) begin
      wait_idle();
      set_ops(vecs[v].idx, vecs[v].hp, vecs[v].dur);
      applyStimulus(4'(1 << vecs[v].idx), 1'b0);
      wait_grant(g);
      checkOutput({vecs[v].name, "_grant"}, 32'(g), 32'(vecs[v].exp_grant));
      applyStimulus('0, 1'b0);
      set_ops(vecs[v].idx, $urandom_range(1, 60000), $urandom_range(1, 900));
      follow_beep(vecs[v].hp, vecs[v].exp_play);
      @(negedge clk);
      checkOutput({vecs[v].name, "_done_once"}, 32'(done), 32'd0);
    end

    // Contention with all requesters holding req, then a sparse mask after the pointer wraps.
    do_reset();
    for (int i = 0; i < N; i++) set_ops(i, 1, 0);
    exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    applyStimulus(4'b1111, 1'b0);
    for (int k = 0; k < 4; k++) begin
      wait_grant(g);
      checkOutput("rr_order", 32'(g), 32'(exp_order[k]));
      applyStimulus(req & ~g, 1'b0);
    end
    wait_idle();
    applyStimulus(4'b0101, 1'b0);
    wait_grant(g);
    checkOutput("rr_sparse_first", 32'(g), 32'b0001);
    applyStimulus(req & ~g, 1'b0);
    wait_grant(g);
    checkOutput("rr_sparse_second", 32'(g), 32'b0100);
    applyStimulus('0, 1'b0);

    // Stop beats a request in IDLE, then aborts a playing beep.
    wait_idle();
    set_ops(0, 2, 3);
    applyStimulus(4'b0001, 1'b1);
    @(negedge clk);
    checkOutput("stop_idle_grant", 32'(grant), 32'd0);
    checkOutput("stop_idle_busy", 32'(busy), 32'd0);
    applyStimulus(4'b0001, 1'b0);
    wait_grant(g);
    checkOutput("abort_grant", 32'(g), 32'b0001);
    applyStimulus('0, 1'b0);
    for (int c = 0; c <= 7; c++) begin
      if (c > 0) @(negedge clk);
      checkOutput("abort_play_buzzer", 32'(buzzer), 32'(model_buzz(2, c)));
    end
    applyStimulus('0, 1'b1);
    @(negedge clk);
    applyStimulus('0, 1'b0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_buzzer", 32'(buzzer), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done !== 1'b0) seen = 1'b1;
    end
    checkOutput("abort_no_done", 32'(seen), 32'd0);

    // Reset in the middle of a high half-period also returns the pointer to 0.
    wait_idle();
    set_ops(1, 3, 3);
    applyStimulus(4'b0010, 1'b0);
    wait_grant(g);
    checkOutput("midreset_grant", 32'(g), 32'b0010);
    applyStimulus('0, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("pre_reset_buzzer", 32'(buzzer), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midreset_grant_low", 32'(grant), 32'd0);
    checkOutput("midreset_busy", 32'(busy), 32'd0);
    checkOutput("midreset_done", 32'(done), 32'd0);
    checkOutput("midreset_buzzer", 32'(buzzer), 32'd0);
    set_ops(2, 2, 1);
    applyStimulus(4'b0110, 1'b0);
    wait_grant(g);
    checkOutput("post_reset_grant", 32'(g), 32'b0010);
    applyStimulus('0, 1'b0);

    // Random request masks and operands against the round-robin and waveform model.
    wait_idle();
    do_reset();
    ptr = 0;
    ok  = 1'b1;
    for (int round = 0; round < 8 && ok; round++) begin
      wait_idle();
      for (int i = 0; i < N; i++) begin
        hp_r[i]  = $urandom_range(0, 4);
        dur_r[i] = $urandom_range(0, 2);
        set_ops(i, hp_r[i], dur_r[i]);
      end
      pending = 4'($urandom_range(1, 15));
      applyStimulus(pending, 1'b0);
      while (pending != '0 && ok) begin
        pred = model_pick(pending, ptr);
        wait_grant(g);
        checkOutput("rand_grant", 32'(g), 32'(1 << pred));
        if (g == '0) ok = 1'b0;
        pending[pred] = 1'b0;
        applyStimulus(pending, 1'b0);
        ptr = (pred + 1) % N;
        set_ops(pred, $urandom_range(1, 60000), $urandom_range(1, 900));
        follow_beep(hp_r[pred], (dur_r[pred] == 0) ? 1 : dur_r[pred] * TD);
      end
    end

    // Separation between a done and the next grant with a request already waiting.
    wait_idle();
    do_reset();
    set_ops(0, 2, 1);
    set_ops(1, 2, 1);
    applyStimulus(4'b0011, 1'b0);
    wait_grant(g);
    checkOutput("gap_first_grant", 32'(g), 32'b0001);
    applyStimulus(4'b0010, 1'b0);
    follow_beep(2, TD);
    n = 0;
    got = 1'b0;
    quiet = 1'b1;
    while (!got && n < 60) begin
      @(negedge clk);
      n++;
      if (grant != '0) got = 1'b1;
      else if (buzzer !== 1'b0) quiet = 1'b0;
    end
    checkOutput("gap_len", 32'(n), 32'(GAP_CYC));
    checkOutput("gap_quiet", 32'(quiet), 32'd1);
    checkOutput("gap_second_grant", 32'(grant), 32'b0010);
    applyStimulus('0, 1'b0);
    follow_beep(2, TD);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
